hps_vector_alu_ctrl: RTL
========================

Name: hps_vector_alu_ctrl

Overview:
- Parametrised successor of the HPS-FPGA PIO control unit.
- Receives two operand vectors of N_ELEM words over a 32-bit PIO input, one word per handshake.
- Applies an opcode-selected element-wise operation sequentially, then returns N_ELEM results over the 32-bit PIO output.
- Sits between the HPS PIO bridge and the FPGA datapath. Adds a 4-phase handshake, operation modes, sticky overflow and abort, none of which the first-generation unit had.

Parameters:
- DATA_W, 8, element width in bits; legal range 2..24.
- N_ELEM, 8, elements per operand vector; legal range 2..64.
- SYNC_STAGES, 3, synchroniser depth for hps_ready; minimum 2.

Ports:
- clk  in  1  system clock, single domain.
- reset  in  1  synchronous, active-high.
- data_in  in  32  PIO from HPS:
  - [31] hps_ready: asynchronous handshake strobe.
  - [30] start.
  - [29:27] opcode.
  - [26] abort.
  - [DATA_W-1:0] payload.
- data_out  out  32  PIO to HPS:
  - [31] fpga_ack.
  - [30] busy.
  - [29] overflow.
  - [28:26] state code.
  - [DATA_W-1:0] result.
  - All other bits 0.
- debug_state  out  4  [2:0] state code, [3] overflow; drives LEDs.

Behaviour:
- Reset, synchronous: state IDLE, counters 0, fpga_ack 0, overflow 0, sync chain 0, data_out 0, debug_state 0. Operand/result RAM contents are don't-care.
- hps_ready passes through SYNC_STAGES flops; rdy_s is the last stage. rise = rdy_s & ~rdy_prev; fall = ~rdy_s & rdy_prev.
- All other data_in bits are sampled directly; the HPS holds them stable while hps_ready is high.
- 4-phase handshake:
  - fpga_ack sets the cycle after an accepted rise and clears the cycle after fall.
  - A rise arriving while fpga_ack=1 is ignored.
- State codes: IDLE=0, RECEIVING=1, PROCESS=2, SENDING=3, RELEASE=4.
- IDLE:
  - start=1 and rdy_s=0 -> RECEIVING.
  - Latch opcode, clear idx and overflow.
- RECEIVING:
  - Each accepted rise writes the payload: words 0..N_ELEM-1 go to A[idx], words N_ELEM..2*N_ELEM-1 go to B[idx-N_ELEM].
  - After word 2*N_ELEM-1 -> PROCESS with idx=0.
- PROCESS: computes one element per cycle, R[i] = op(A[i],B[i]), i.e. exactly N_ELEM cycles, then -> SENDING with idx=0.
- Opcodes:
  - 000 ADD: result modulo 2^DATA_W; carry out sets overflow.
  - 001 SUB: A-B modulo 2^DATA_W; borrow sets overflow.
  - 010 MUL: low DATA_W bits of the product; any nonzero high half sets overflow.
  - 011 MAX: unsigned maximum.
  - 100 AND.
  - 101..111: R=A, and overflow is set once to flag an illegal op.
- SENDING:
  - data_out[DATA_W-1:0] = R[idx] combinationally; it is 0 in every other state.
  - HPS reads, then raises hps_ready. An accepted rise increments idx.
  - On the rise for idx=N_ELEM-1 -> RELEASE.
- RELEASE:
  - Wait for start=0 -> IDLE; prevents retrigger.
  - overflow stays visible until the next start.
- Abort: abort=1 in any state except IDLE -> IDLE next cycle. idx, fpga_ack and busy clear; overflow is kept.
- Abort has priority over every other transition. start is ignored outside IDLE.
- busy = (state != IDLE).
- Counter widths: $clog2(2*N_ELEM). No wrap beyond the terminal count.
- A rise and a fall cannot occur in the same cycle; no special case is needed.

Decomposition:
- Shared package hps_pio_pkg holds:
  - state codes;
  - opcode constants;
  - PIO bit-position constants: HPS_READY_BIT=31, START_BIT=30, OPCODE_MSB/LSB=29/27, ABORT_BIT=26, ACK_BIT=31, BUSY_BIT=30, OVF_BIT=29, STATE_MSB/LSB=28/26.
- One natural sub-module: hps_handshake_sync. It contains the SYNC_STAGES synchroniser, rise/fall detect and the fpga_ack set/clear logic, and is reused by later PIO blocks.
- The element ALU stays inline as a case on the latched opcode.

Test Plan:
- Reset, then start with op ADD; send A=1..8 and B=10..80 (step 10) -> R read back 11,22,...,88; overflow=0; state returns to 4 then 0 after start drops.
- ADD with A[0]=200, B[0]=100 (DATA_W=8) -> R[0]=44, overflow=1, debug_state[3]=1; overflow clears at the next start.
- Hold hps_ready high across 5 clocks per word -> exactly one word is accepted per pulse; fpga_ack rises 1 cycle after rdy_s rises and falls 1 cycle after rdy_s falls.
- Abort after 5 received words -> IDLE next cycle, busy=0, ack=0. A new ADD transaction then completes correctly from word 0.
- MUL with A[3]=16, B[3]=17 -> R[3]=0x10, overflow=1. MAX with A[2]=3, B[2]=9 -> R[2]=9.
- Opcode 111 -> R equals A; overflow=1; PROCESS lasts exactly N_ELEM=8 cycles (check state code 2 for 8 clocks).

Source files
------------

// File: rtl/hps_pio_pkg.sv
// hps_pio_pkg: state codes, opcodes and PIO bit positions shared by the HPS PIO blocks
package hps_pio_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RECEIVING = 3'd1,
        ST_PROCESS   = 3'd2,
        ST_SENDING   = 3'd3,
        ST_RELEASE   = 3'd4
    } state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_MAX = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;

    localparam int HPS_READY_BIT = 31;
    localparam int START_BIT     = 30;
    localparam int OPCODE_MSB    = 29;
    localparam int OPCODE_LSB    = 27;
    localparam int ABORT_BIT     = 26;

    localparam int ACK_BIT   = 31;
    localparam int BUSY_BIT  = 30;
    localparam int OVF_BIT   = 29;
    localparam int STATE_MSB = 28;
    localparam int STATE_LSB = 26;

endpackage

// File: rtl/hps_vector_alu_ctrl_if.sv
// hps_vector_alu_ctrl_if: 32-bit PIO pair between the HPS bridge and the vector ALU controller
interface hps_vector_alu_ctrl_if;

    logic [31:0] data_in;
    logic [31:0] data_out;

    modport master (output data_in, input data_out);
    modport slave  (input data_in, output data_out);

endinterface

// File: rtl/hps_handshake_sync.sv
// hps_handshake_sync: hps_ready synchroniser, edge detect and 4-phase fpga_ack generation
module hps_handshake_sync #(
    parameter int SYNC_STAGES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic hps_ready_i,
    input  logic en_i,
    input  logic clr_i,
    output logic rdy_s_o,
    output logic accept_o,
    output logic ack_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rdy_prev_q;
    logic                   ack_q;
    logic                   ack_d;
    logic                   rise;
    logic                   fall;

    assign rdy_s_o  = sync_q[SYNC_STAGES-1];
    assign rise     = rdy_s_o & ~rdy_prev_q;
    assign fall     = ~rdy_s_o & rdy_prev_q;
    // a rise while ack is still high belongs to a handshake already consumed
    assign accept_o = rise & ~ack_q & en_i;
    assign ack_o    = ack_q;

    // ack: abort clears, accepted rise sets, synchronised fall clears
    always_comb ack_d = clr_i ? 1'b0 : accept_o ? 1'b1 : fall ? 1'b0 : ack_q;

    // synchroniser chain, edge history and ack register
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= '0;
            rdy_prev_q <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], hps_ready_i};
            rdy_prev_q <= rdy_s_o;
            ack_q      <= ack_d;
        end
    end

endmodule

// File: rtl/hps_vector_alu_ctrl.sv
// hps_vector_alu_ctrl: receives two operand vectors over PIO, applies an element-wise op, returns results
module hps_vector_alu_ctrl
    import hps_pio_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int N_ELEM      = 8,
    parameter int SYNC_STAGES = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    hps_vector_alu_ctrl_if.slave pio,
    output logic [3:0]           debug_state
);

    localparam int IW = $clog2(2 * N_ELEM);
    localparam int AW = $clog2(N_ELEM);

    typedef logic [DATA_W-1:0] elem_t;

    elem_t              a_q [N_ELEM];
    elem_t              b_q [N_ELEM];
    elem_t              r_q [N_ELEM];
    state_t             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [2:0]         op_q, op_d;
    logic               ovf_q, ovf_d;
    logic               wr_a, wr_b, wr_r;
    logic               start, abort, busy;
    logic [2:0]         opcode;
    elem_t              payload;
    logic               rdy_s, accept, ack;
    logic [AW-1:0]      eidx, bidx;
    elem_t              ea, eb, alu_r;
    logic               alu_v;
    logic [DATA_W:0]    sum;
    logic [2*DATA_W-1:0] prod;
    logic               unused_bits;

    assign start       = pio.data_in[START_BIT];
    assign abort       = pio.data_in[ABORT_BIT];
    assign opcode      = pio.data_in[OPCODE_MSB:OPCODE_LSB];
    assign payload     = pio.data_in[DATA_W-1:0];
    assign unused_bits = ^pio.data_in[ABORT_BIT-1:DATA_W];
    assign busy        = state_q != ST_IDLE;
    assign eidx        = idx_q[AW-1:0];
    assign bidx        = AW'(idx_q - IW'(N_ELEM));
    assign ea          = a_q[eidx];
    assign eb          = b_q[eidx];
    assign sum         = {1'b0, ea} + {1'b0, eb};
    assign prod        = {{DATA_W{1'b0}}, ea} * {{DATA_W{1'b0}}, eb};

    hps_handshake_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_hs (
        .clk        (clk),
        .reset      (reset),
        .hps_ready_i(pio.data_in[HPS_READY_BIT]),
        .en_i       (state_q == ST_RECEIVING || state_q == ST_SENDING),
        .clr_i      (abort && busy),
        .rdy_s_o    (rdy_s),
        .accept_o   (accept),
        .ack_o      (ack)
    );

    // element ALU on the latched opcode; alu_v flags overflow, borrow or an illegal op
    always_comb begin
        alu_r = ea;
        alu_v = 1'b0;
        case (op_q)
            OP_ADD:  begin alu_r = sum[DATA_W-1:0];  alu_v = sum[DATA_W]; end
            OP_SUB:  begin alu_r = ea - eb;          alu_v = ea < eb; end
            OP_MUL:  begin alu_r = prod[DATA_W-1:0]; alu_v = |prod[2*DATA_W-1:DATA_W]; end
            OP_MAX:  alu_r = (ea > eb) ? ea : eb;
            OP_AND:  alu_r = ea & eb;
            default: alu_v = 1'b1;
        endcase
    end

    // next state, index, opcode and overflow; abort overrides everything outside IDLE
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        op_d    = op_q;
        ovf_d   = ovf_q;
        wr_a    = 1'b0;
        wr_b    = 1'b0;
        wr_r    = 1'b0;
        if (abort && busy) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: if (start && !rdy_s) begin
                    state_d = ST_RECEIVING;
                    op_d    = opcode;
                    idx_d   = '0;
                    ovf_d   = 1'b0;
                end
                ST_RECEIVING: if (accept) begin
                    wr_a = idx_q < IW'(N_ELEM);
                    wr_b = !wr_a;
                    state_d = (idx_q == IW'(2 * N_ELEM - 1)) ? ST_PROCESS : ST_RECEIVING;
                    idx_d   = (idx_q == IW'(2 * N_ELEM - 1)) ? '0 : idx_q + IW'(1);
                end
                ST_PROCESS: begin
                    wr_r    = 1'b1;
                    ovf_d   = ovf_q | alu_v;
                    state_d = (idx_q == IW'(N_ELEM - 1)) ? ST_SENDING : ST_PROCESS;
                    idx_d   = (idx_q == IW'(N_ELEM - 1)) ? '0 : idx_q + IW'(1);
                end
                ST_SENDING: if (accept) begin
                    state_d = (idx_q == IW'(N_ELEM - 1)) ? ST_RELEASE : ST_SENDING;
                    idx_d   = (idx_q == IW'(N_ELEM - 1)) ? idx_q : idx_q + IW'(1);
                end
                ST_RELEASE: if (!start) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // control state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            op_q    <= OP_ADD;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            ovf_q   <= ovf_d;
        end
    end

    // operand and result storage, contents undefined after reset
    always_ff @(posedge clk) begin
        if (wr_a) a_q[eidx] <= payload;
        if (wr_b) b_q[bidx] <= payload;
        if (wr_r) r_q[eidx] <= alu_r;
    end

    // status word back to the HPS; result lane only live while sending
    always_comb begin
        pio.data_out                      = '0;
        pio.data_out[ACK_BIT]             = ack;
        pio.data_out[BUSY_BIT]            = busy;
        pio.data_out[OVF_BIT]             = ovf_q;
        pio.data_out[STATE_MSB:STATE_LSB] = state_q;
        pio.data_out[DATA_W-1:0]          = (state_q == ST_SENDING) ? r_q[eidx] : '0;
    end

    assign debug_state = {ovf_q, state_q};

endmodule
